// File: rtl/vram_write_arbiter.sv
// vram_write_arbiter: shares the single VRAM write port between buffered CPU
// writes (FIFO) and a constant-byte fill engine. Writes are only issued while
// video timing reports `writable`. Contention alternates round-robin, and the
// CPU wins the first contention after reset.
//
// Handshake: a CPU write is accepted on any rising edge where cpu_valid and
// cpu_ready are both high. cpu_ready depends only on the FIFO not being full,
// so a pop in the same cycle never makes room for a push.
//
// Optional build macro VRAM_ARB_STATS_EN adds the stall_count and fifo_hwm
// statistics outputs. Without the macro, those ports and their logic are absent.
// dbg_fill_state exposes the fill FSM state (0 = IDLE, 1 = FILL).

`ifndef VRAM_ADDR_WIDTH
`define VRAM_ADDR_WIDTH 12
`endif

module vram_write_arbiter #(
  parameter int ADDR_WIDTH = `VRAM_ADDR_WIDTH,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    writable,
  input  logic                    cpu_valid,
  output logic                    cpu_ready,
  input  logic [ADDR_WIDTH-1:0]   cpu_addr,
  input  logic [7:0]              cpu_data,
  input  logic                    fill_start,
  input  logic [ADDR_WIDTH-1:0]   fill_base,
  input  logic [ADDR_WIDTH:0]     fill_len,
  input  logic [7:0]              fill_value,
  output logic                    fill_busy,
  output logic                    fill_done,
  output logic                    vram_we,
  output logic [ADDR_WIDTH-1:0]   vram_address,
  output logic [7:0]              vram_data,
`ifdef VRAM_ARB_STATS_EN
  output logic [15:0]             stall_count,
  output logic [$clog2(FIFO_DEPTH):0] fifo_hwm,
`endif
  output logic                    dbg_fill_state
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int ENT_W = ADDR_WIDTH + 8;
  localparam logic [CNT_W-1:0]      DEPTH_CNT = CNT_W'(FIFO_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] ONE_ADDR  = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH:0]   ONE_LEN   = (ADDR_WIDTH + 1)'(1);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_FILL = 1'b1
  } fill_state_e;

  // round-robin memory: which source was granted most recently
  localparam logic RR_CPU  = 1'b0;
  localparam logic RR_FILL = 1'b1;

  // ---------------- CPU FIFO ----------------
  logic [ENT_W-1:0] fifo_mem_q [FIFO_DEPTH];
  logic [CNT_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] fifo_count;
  logic             fifo_full;
  logic             fifo_empty;
  logic             push;
  logic [ENT_W-1:0] fifo_head;

  // ---------------- fill engine ----------------
  fill_state_e             state_q, state_d;
  logic [ADDR_WIDTH-1:0]   cur_q, cur_d;
  logic [ADDR_WIDTH:0]     rem_q, rem_d;
  logic [7:0]              val_q, val_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;

  // ---------------- arbitration / output ----------------
  logic                    rr_last_q, rr_last_d;
  logic                    cpu_req, fill_req;
  logic                    grant_cpu, grant_fill;
  logic                    we_q, we_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [7:0]              data_q, data_d;

  assign fifo_count = wr_ptr_q - rd_ptr_q;
  assign fifo_full  = (fifo_count == DEPTH_CNT);
  assign fifo_empty = (fifo_count == '0);
  assign cpu_ready  = !fifo_full;
  assign push       = cpu_valid && !fifo_full;
  assign fifo_head  = fifo_mem_q[rd_ptr_q[PTR_W-1:0]];

  // Requests and round-robin grant; nothing is granted outside writable windows.
  always_comb begin
    cpu_req    = !fifo_empty;
    fill_req   = (state_q == S_FILL);
    grant_cpu  = 1'b0;
    grant_fill = 1'b0;
    if (writable) begin
      if (cpu_req && fill_req) begin
        grant_cpu  = (rr_last_q == RR_FILL);
        grant_fill = (rr_last_q == RR_CPU);
      end else begin
        grant_cpu  = cpu_req;
        grant_fill = fill_req;
      end
    end
  end

  // FIFO pointer next-state: push on accepted CPU write, pop on CPU grant.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push)      wr_ptr_d = wr_ptr_q + CNT_W'(1);
    if (grant_cpu) rd_ptr_d = rd_ptr_q + CNT_W'(1);
  end

  // FIFO storage; entries need no reset because the pointers define validity.
  always_ff @(posedge clk) begin
    if (rst && push) begin
      fifo_mem_q[wr_ptr_q[PTR_W-1:0]] <= {cpu_addr, cpu_data};
    end
  end

  // Fill FSM next-state: latch a job from IDLE, walk addresses on each grant.
  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    rem_d   = rem_q;
    val_d   = val_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (fill_start) begin
          if (fill_len != '0) begin
            state_d = S_FILL;
            cur_d   = fill_base;
            rem_d   = fill_len;
            val_d   = fill_value;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      S_FILL: begin
        if (grant_fill) begin
          cur_d = cur_q + ONE_ADDR;
          rem_d = rem_q - ONE_LEN;
          if (rem_q == ONE_LEN) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d == S_FILL);
  end

  // Output register and round-robin next-state: load the granted entry.
  always_comb begin
    we_d      = grant_cpu || grant_fill;
    addr_d    = addr_q;
    data_d    = data_q;
    rr_last_d = rr_last_q;
    if (grant_cpu) begin
      addr_d    = fifo_head[ENT_W-1:8];
      data_d    = fifo_head[7:0];
      rr_last_d = RR_CPU;
    end else if (grant_fill) begin
      addr_d    = cur_q;
      data_d    = val_q;
      rr_last_d = RR_FILL;
    end
  end

  // State registers; reset flushes the FIFO and aborts any fill silently.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      state_q   <= S_IDLE;
      cur_q     <= '0;
      rem_q     <= '0;
      val_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      rr_last_q <= RR_FILL;
      we_q      <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      state_q   <= state_d;
      cur_q     <= cur_d;
      rem_q     <= rem_d;
      val_q     <= val_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      rr_last_q <= rr_last_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
    end
  end

  assign fill_busy      = busy_q;
  assign fill_done      = done_q;
  assign vram_we        = we_q;
  assign vram_address   = addr_q;
  assign vram_data      = data_q;
  assign dbg_fill_state = state_q;

`ifdef VRAM_ARB_STATS_EN
  logic [15:0]      stall_q, stall_d;
  logic [CNT_W-1:0] hwm_q, hwm_d;

  // Stall counter saturates; high-water mark tracks peak FIFO occupancy.
  always_comb begin
    stall_d = stall_q;
    hwm_d   = hwm_q;
    if ((cpu_req || fill_req) && !writable && (stall_q != 16'hFFFF)) begin
      stall_d = stall_q + 16'd1;
    end
    if (fifo_count > hwm_q) begin
      hwm_d = fifo_count;
    end
  end

  // Statistics registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      stall_q <= '0;
      hwm_q   <= '0;
    end else begin
      stall_q <= stall_d;
      hwm_q   <= hwm_d;
    end
  end

  assign stall_count = stall_q;
  assign fifo_hwm    = hwm_q;
`endif

endmodule

// File: tb/tb_vram_write_arbiter.sv
// Bench for vram_write_arbiter: directed scenarios followed by random traffic,
// every cycle compared against a queue-based transaction model.
module tb_vram_write_arbiter;

  localparam int AW    = 12;
  localparam int DEPTH = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          writable;
  logic          cpu_valid;
  logic          cpu_ready;
  logic [AW-1:0] cpu_addr;
  logic [7:0]    cpu_data;
  logic          fill_start;
  logic [AW-1:0] fill_base;
  logic [AW:0]   fill_len;
  logic [7:0]    fill_value;
  logic          fill_busy;
  logic          fill_done;
  logic          vram_we;
  logic [AW-1:0] vram_address;
  logic [7:0]    vram_data;
  logic          dbg_fill_state;
`ifdef VRAM_ARB_STATS_EN
  logic [15:0]   stall_count;
  logic [$clog2(DEPTH):0] fifo_hwm;
`endif

  vram_write_arbiter #(.ADDR_WIDTH(AW), .FIFO_DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst            (rst),
    .writable       (writable),
    .cpu_valid      (cpu_valid),
    .cpu_ready      (cpu_ready),
    .cpu_addr       (cpu_addr),
    .cpu_data       (cpu_data),
    .fill_start     (fill_start),
    .fill_base      (fill_base),
    .fill_len       (fill_len),
    .fill_value     (fill_value),
    .fill_busy      (fill_busy),
    .fill_done      (fill_done),
    .vram_we        (vram_we),
    .vram_address   (vram_address),
    .vram_data      (vram_data),
`ifdef VRAM_ARB_STATS_EN
    .stall_count    (stall_count),
    .fifo_hwm       (fifo_hwm),
`endif
    .dbg_fill_state (dbg_fill_state)
  );

  // ---------------- reference model ----------------
  logic [AW+7:0] exp_q[$];     // pending CPU writes in issue order
  bit            m_fill;       // fill job outstanding
  logic [AW-1:0] m_cur;
  int            m_rem;
  logic [7:0]    m_val;
  bit            m_rr_fill;    // last grant went to fill
  logic          m_we, m_busy, m_done, m_ready;
  logic [AW-1:0] m_addr;
  logic [7:0]    m_data;

  int n_cmp = 0;
  int n_bad = 0;
  int wr_count = 0;
  int done_count = 0;
  logic [AW+7:0] wlog[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance the model by one clock edge using the inputs currently driven.
  task automatic model_edge();
    bit can_push, cpu_has, fill_was, give_cpu, give_fill;
    logic [AW+7:0] e;
    if (!rst) begin
      exp_q.delete();
      m_fill    = 0;
      m_rr_fill = 1;
      m_we      = 1'b0;
      m_addr    = '0;
      m_data    = '0;
      m_done    = 1'b0;
    end else begin
      can_push  = exp_q.size() < DEPTH;
      cpu_has   = exp_q.size() > 0;
      fill_was  = m_fill;
      give_cpu  = 0;
      give_fill = 0;
      if (writable) begin
        if (cpu_has && fill_was) begin
          if (m_rr_fill) give_cpu = 1; else give_fill = 1;
        end else begin
          give_cpu  = cpu_has;
          give_fill = fill_was;
        end
      end
      m_done = 1'b0;
      m_we   = 1'b0;
      if (give_cpu) begin
        e         = exp_q.pop_front();
        m_we      = 1'b1;
        m_addr    = e[AW+7:8];
        m_data    = e[7:0];
        m_rr_fill = 0;
      end
      if (give_fill) begin
        m_we      = 1'b1;
        m_addr    = m_cur;
        m_data    = m_val;
        m_cur     = m_cur + 1'b1;
        m_rem     = m_rem - 1;
        m_rr_fill = 1;
        if (m_rem == 0) begin
          m_fill = 0;
          m_done = 1'b1;
        end
      end
      if (!fill_was && fill_start) begin
        if (fill_len != 0) begin
          m_fill = 1;
          m_cur  = fill_base;
          m_rem  = int'(fill_len);
          m_val  = fill_value;
        end else begin
          m_done = 1'b1;
        end
      end
      if (cpu_valid && can_push) exp_q.push_back({cpu_addr, cpu_data});
    end
    m_busy  = m_fill;
    m_ready = exp_q.size() < DEPTH;
  endtask

  // ---------------- driver: one clock with full output check ----------------
  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    if (vram_we === 1'b1) begin
      wr_count++;
      wlog.push_back({vram_address, vram_data});
    end
    if (fill_done === 1'b1) done_count++;
    chk("vram_we",   32'(vram_we),        32'(m_we));
    chk("vram_addr", 32'(vram_address),   32'(m_addr));
    chk("vram_data", 32'(vram_data),      32'(m_data));
    chk("fill_busy", 32'(fill_busy),      32'(m_busy));
    chk("fill_done", 32'(fill_done),      32'(m_done));
    chk("cpu_ready", 32'(cpu_ready),      32'(m_ready));
    chk("dbg_state", 32'(dbg_fill_state), 32'(m_busy));
  endtask

  int w0, d0;
  logic [AW+7:0] ent;

  initial begin
    rst = 1'b0; writable = 1'b0; cpu_valid = 1'b0; cpu_addr = '0; cpu_data = '0;
    fill_start = 1'b0; fill_base = '0; fill_len = '0; fill_value = '0;
    m_fill = 0; m_cur = '0; m_rem = 0; m_val = '0; m_rr_fill = 1;

    // reset
    step(); step();
    chk("rst_we", 32'(vram_we), 32'd0);
    chk("rst_ready", 32'(cpu_ready), 32'd1);
    rst = 1'b1;

    // single CPU write latency
    writable = 1'b1; cpu_valid = 1'b1; cpu_addr = AW'('h010); cpu_data = 8'hA5;
    step();
    cpu_valid = 1'b0;
    step();
    chk("t1_we", 32'(vram_we), 32'd1);
    chk("t1_addr", 32'(vram_address), 32'h010);
    chk("t1_data", 32'(vram_data), 32'hA5);

    // fill the FIFO while not writable, then drain
    writable = 1'b0;
    for (int i = 0; i < 17; i++) begin
      cpu_valid = 1'b1; cpu_addr = AW'('h100 + i); cpu_data = 8'(i);
      step();
      if (i == 15) chk("t2_full", 32'(cpu_ready), 32'd0);
    end
    cpu_valid = 1'b0; writable = 1'b1; w0 = wr_count; wlog.delete();
    for (int i = 0; i < 17; i++) step();
    chk("t2_writes", 32'(wr_count - w0), 32'd16);
    for (int i = 0; i < 16; i++) begin
      ent = wlog[i];
      chk("t2_order", 32'(ent), 32'({AW'('h100 + i), 8'(i)}));
    end

    // wrapping fill
    wlog.delete(); d0 = done_count;
    fill_base = AW'((1 << AW) - 2); fill_len = (AW+1)'(4); fill_value = 8'h3C; fill_start = 1'b1;
    step();
    fill_start = 1'b0;
    for (int i = 0; i < 6; i++) step();
    chk("t3_count", 32'(wlog.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      ent = wlog[i];
      chk("t3_write", 32'(ent), 32'({AW'((1 << AW) - 2 + i), 8'h3C}));
    end
    chk("t3_done", 32'(done_count - d0), 32'd1);
    chk("t3_busy", 32'(fill_busy), 32'd0);

    // round-robin contention from fresh reset
    rst = 1'b0; step(); rst = 1'b1;
    writable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cpu_valid = 1'b1; cpu_addr = AW'('h200 + i); cpu_data = 8'(8'h11 * (i + 1));
      fill_start = (i == 2); fill_base = AW'('h300); fill_len = (AW+1)'(3); fill_value = 8'hEE;
      step();
    end
    cpu_valid = 1'b0; fill_start = 1'b0; writable = 1'b1; wlog.delete();
    for (int i = 0; i < 8; i++) step();
    chk("t4_count", 32'(wlog.size()), 32'd6);
    for (int i = 0; i < 6; i++) begin
      ent = wlog[i];
      chk("t4_order", 32'(ent[7:0]), (i % 2 == 0) ? 32'(8'h11 * (i / 2 + 1)) : 32'hEE);
    end

    // long fill through writable gaps, ignored restart, zero-length fill
    w0 = wr_count; d0 = done_count;
    fill_base = AW'($urandom_range(0, (1 << AW) - 1)); fill_value = 8'h5A;
    for (int i = 0; i < 260; i++) begin
      writable   = ((i / 5) % 2) == 0;
      fill_start = (i == 0) || (i == 20);
      fill_len   = (i == 0) ? (AW+1)'(100) : (AW+1)'(7);
      step();
    end
    fill_start = 1'b0;
    chk("t5_writes", 32'(wr_count - w0), 32'd100);
    chk("t5_done", 32'(done_count - d0), 32'd1);
    w0 = wr_count;
    fill_len = '0; fill_start = 1'b1;
    step();
    fill_start = 1'b0;
    chk("t5_zero_done", 32'(fill_done), 32'd1);
    step();
    chk("t5_zero_writes", 32'(wr_count - w0), 32'd0);

    // reset during a fill with CPU traffic pending
    writable = 1'b0;
    for (int i = 0; i < 2; i++) begin
      cpu_valid = 1'b1; cpu_addr = AW'('h400 + i); cpu_data = 8'(i + 1);
      step();
    end
    cpu_valid = 1'b0; fill_len = (AW+1)'(50); fill_base = AW'('h500); fill_start = 1'b1;
    step();
    fill_start = 1'b0; writable = 1'b1;
    for (int i = 0; i < 4; i++) step();
    rst = 1'b0; cpu_valid = 1'b1; fill_start = 1'b1; d0 = done_count;
    step();
    chk("t6_we", 32'(vram_we), 32'd0);
    chk("t6_busy", 32'(fill_busy), 32'd0);
    chk("t6_ready", 32'(cpu_ready), 32'd1);
    rst = 1'b1; cpu_valid = 1'b0; fill_start = 1'b0; w0 = wr_count;
    for (int i = 0; i < 10; i++) step();
    chk("t6_no_writes", 32'(wr_count - w0), 32'd0);
    chk("t6_no_done", 32'(done_count - d0), 32'd0);

    // random traffic
    for (int i = 0; i < 600; i++) begin
      rst        = ($urandom_range(0, 199) != 0);
      writable   = ($urandom_range(0, 3) != 0);
      cpu_valid  = $urandom_range(0, 1) == 1;
      cpu_addr   = AW'($urandom_range(0, (1 << AW) - 1));
      cpu_data   = 8'($urandom_range(0, 255));
      fill_start = ($urandom_range(0, 15) == 0);
      fill_base  = AW'($urandom_range(0, (1 << AW) - 1));
      fill_len   = (AW+1)'($urandom_range(0, 12));
      fill_value = 8'($urandom_range(0, 255));
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
